// File: rtl/systolic_skew_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder_if
// Bundles the feeder's upstream valid/ready stream and its array-side outputs.
//   slave  modport : the feeder (consumes in_*, drives in_ready and arr_*).
//   master modport : the upstream/array side (drives in_*, observes the rest).
// Signals:
//   in_valid / in_ready / in_data / in_last : upstream vector handshake
//   arr_en / arr_data / arr_lane_vld        : skewed west-edge feed
//   busy / done                             : tile status
//   stat_beats / stat_tiles                 : only with SKEW_FEEDER_STATS_EN
// ---------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
    parameter int DATA_W = 16,
    parameter int N      = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   in_data;
    logic                  in_last;
    logic                  arr_en;
    logic [N*DATA_W-1:0]   arr_data;
    logic [N-1:0]          arr_lane_vld;
    logic                  busy;
    logic                  done;
`ifdef SKEW_FEEDER_STATS_EN
    logic [31:0]           stat_beats;
    logic [31:0]           stat_tiles;
`endif

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, arr_en, arr_data, arr_lane_vld, busy, done
`ifdef SKEW_FEEDER_STATS_EN
        , output stat_beats, stat_tiles
`endif
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, arr_en, arr_data, arr_lane_vld, busy, done
`ifdef SKEW_FEEDER_STATS_EN
        , input stat_beats, stat_tiles
`endif
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
// West-edge feeder for the pe_mac systolic array. Each accepted N-lane vector
// is pushed into per-lane shift chains; lane i has i+1 stages so its operand
// reaches the array i advance steps later than lane 0. After the last vector
// of a tile, N-1 zero flush steps push the skewed tail fully into the array.
//
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : systolic_skew_feeder_if.slave
//            in_valid/in_ready/in_data/in_last  upstream handshake
//            arr_en        array advance enable (registered advance)
//            arr_data      skewed operands, lane i at [i*DATA_W +: DATA_W]
//            arr_lane_vld  lane carries real data (1) or pad zero (0)
//            busy          tile in progress (STREAM or FLUSH)
//            done          one-cycle pulse with the final skewed element
// Optional feature (macro SKEW_FEEDER_STATS_EN): stat_beats counts accepted
// vectors, stat_tiles counts done pulses; both wrap and clear on reset.
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
    parameter int DATA_W = 16,
    parameter int N      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    systolic_skew_feeder_if.slave   bus
);
    localparam int                 CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_flush_cnt;
    logic [CNT_W-1:0]     w_flush_cnt_next;
    logic                 r_arr_en;
    logic                 r_done;
    logic                 w_done_next;
    logic                 w_in_ready;
    logic                 w_fire;
    logic                 w_flush_step;
    logic                 w_advance;
    logic [N*DATA_W-1:0]  w_arr_data;
    logic [N-1:0]         w_arr_lane_vld;

    // Ready depends only on state and reset, never on in_valid.
    assign w_in_ready   = rst_n & (r_state != S_FLUSH);
    assign w_fire       = bus.in_valid & w_in_ready;
    assign w_flush_step = (r_state == S_FLUSH);
    assign w_advance    = w_fire | w_flush_step;

    // Next-state logic. The done pulse is scheduled on the edge that makes
    // the last real element of lane N-1 visible: the final flush step, or
    // (single-lane case) the in_last fire itself.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_done_next      = 1'b0;
        case (r_state)
            S_IDLE, S_STREAM: begin
                if (w_fire) begin
                    if (bus.in_last) begin
                        if (N > 1) begin
                            w_state_next     = S_FLUSH;
                            w_flush_cnt_next = CNT_LOAD;
                        end else begin
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_state_next = S_STREAM;
                    end
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == CNT_ONE) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
            r_arr_en    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_arr_en    <= w_advance;
            r_done      <= w_done_next;
        end
    end

    // Per-lane skew chains. All chains move together on advance and freeze
    // otherwise, so upstream bubbles never disturb the diagonal alignment.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DATA_W-1:0] r_stage_data [gi+1];
        logic [gi:0]       r_stage_vld;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s <= gi; s++) begin
                    r_stage_data[s] <= '0;
                    r_stage_vld[s]  <= 1'b0;
                end
            end else if (w_advance) begin
                r_stage_data[0] <= w_fire ? bus.in_data[gi*DATA_W +: DATA_W] : '0;
                r_stage_vld[0]  <= w_fire;
                for (int s = 1; s <= gi; s++) begin
                    r_stage_data[s] <= r_stage_data[s-1];
                    r_stage_vld[s]  <= r_stage_vld[s-1];
                end
            end
        end

        assign w_arr_data[gi*DATA_W +: DATA_W] = r_stage_data[gi];
        assign w_arr_lane_vld[gi]              = r_stage_vld[gi];
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.arr_en       = r_arr_en;
    assign bus.arr_data     = w_arr_data;
    assign bus.arr_lane_vld = w_arr_lane_vld;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;

`ifdef SKEW_FEEDER_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_tiles;

    // stat_tiles steps on the same edge that raises done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_beats <= '0;
            r_stat_tiles <= '0;
        end else begin
            if (w_fire) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if (w_done_next) begin
                r_stat_tiles <= r_stat_tiles + 32'd1;
            end
        end
    end

    assign bus.stat_beats = r_stat_beats;
    assign bus.stat_tiles = r_stat_tiles;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_skew_feeder
// Reference model: every advance appends one column (the accepted vector, or
// a zero pad during flush) to a history queue. After A advances, lane i shows
// column A-1-i, or zero if that column does not exist yet. Tile progress is
// tracked as "flush steps still owed" after an in_last fire.
// ---------------------------------------------------------------------------
module tb_systolic_skew_feeder;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int W  = N * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DATA_W(DW), .N(N)) bus ();

    systolic_skew_feeder #(.DATA_W(DW), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [W-1:0] hist_d[$];
    bit           hist_v[$];
    int           m_flush_rem = 0;
    bit           m_stream    = 0;
    bit           m_arr_en    = 0;
    bit           m_done      = 0;
    bit           m_fire      = 0;
    bit           m_started   = 0;
    int unsigned  m_beats     = 0;
    int unsigned  m_tiles     = 0;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (!rst_n) begin
            hist_d.delete();
            hist_v.delete();
            m_flush_rem = 0;
            m_stream    = 0;
            m_arr_en    = 0;
            m_done      = 0;
            m_beats     = 0;
            m_tiles     = 0;
        end else begin
            m_fire = bus.in_valid && (m_flush_rem == 0);
            m_done = 0;
            if (m_fire) begin
                hist_d.push_back(bus.in_data);
                hist_v.push_back(1'b1);
                m_beats++;
                m_arr_en = 1;
                if (bus.in_last) begin
                    m_stream = 0;
                    if (N > 1) m_flush_rem = N - 1;
                    else       m_done = 1;
                end else begin
                    m_stream = 1;
                end
            end else if (m_flush_rem > 0) begin
                hist_d.push_back('0);
                hist_v.push_back(1'b0);
                m_flush_rem--;
                m_arr_en = 1;
                if (m_flush_rem == 0) m_done = 1;
            end else begin
                m_arr_en = 0;
            end
            if (m_done) m_tiles++;
        end
    end

    function automatic logic [W-1:0] exp_data();
        logic [W-1:0] r;
        logic [W-1:0] col;
        int idx;
        r = '0;
        for (int i = 0; i < N; i++) begin
            idx = hist_d.size() - 1 - i;
            if (idx >= 0) begin
                col = hist_d[idx];
                r[i*DW +: DW] = col[i*DW +: DW];
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_vld();
        logic [N-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < N; i++) begin
            idx = hist_d.size() - 1 - i;
            if (idx >= 0) r[i] = hist_v[idx];
        end
        return r;
    endfunction

    // One compare process, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready", 64'(bus.in_ready), 64'(rst_n && (m_flush_rem == 0)));
            check("arr_en",   64'(bus.arr_en),   64'(m_arr_en));
            check("done",     64'(bus.done),     64'(m_done));
            check("busy",     64'(bus.busy),     64'(m_stream || (m_flush_rem > 0)));
            check("arr_data", 64'(bus.arr_data), 64'(exp_data()));
            check("lane_vld", 64'(bus.arr_lane_vld), 64'(exp_vld()));
`ifdef SKEW_FEEDER_STATS_EN
            check("stat_beats", 64'(bus.stat_beats), 64'(m_beats));
            check("stat_tiles", 64'(bus.stat_tiles), 64'(m_tiles));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Capture of raw outputs for hand-computed literal expectations
    // ------------------------------------------------------------------
    bit cap_en = 0;
    int cap_n  = 0;
    bit c_en[64], c_done[64], c_rdy[64], c_v3[64];
    int c_l0[64], c_l3[64];

    always @(negedge clk) begin
        if (cap_en && cap_n < 64) begin
            c_en[cap_n]   = bus.arr_en;
            c_done[cap_n] = bus.done;
            c_rdy[cap_n]  = bus.in_ready;
            c_v3[cap_n]   = bus.arr_lane_vld[3];
            c_l0[cap_n]   = int'(bus.arr_data[DW-1:0]);
            c_l3[cap_n]   = int'(bus.arr_data[3*DW +: DW]);
            cap_n++;
        end
    end

    int e_l0[5] = '{1, 5, 0, 0, 0};
    int e_l3[5] = '{0, 0, 0, 4, 8};
    int e_v3[5] = '{0, 0, 0, 1, 1};

    // Checks one captured 2-vector tile: lane sequences, done position,
    // ready-low count, and the number of arr_en-low cycles inside the burst.
    task automatic analyze_tile(input string tag, input int exp_gap);
        int hi[$];
        int rdy_low, dn;
        rdy_low = 0;
        dn = 0;
        for (int i = 0; i < cap_n; i++) begin
            if (c_en[i]) hi.push_back(i);
            if (!c_rdy[i]) rdy_low++;
            if (c_done[i]) dn++;
        end
        check({tag, "_en_count"}, 64'(hi.size()), 64'(5));
        check({tag, "_ready_low"}, 64'(rdy_low), 64'(3));
        check({tag, "_done_count"}, 64'(dn), 64'(1));
        if (hi.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check({tag, "_lane0"}, 64'(c_l0[hi[k]]), 64'(e_l0[k]));
                check({tag, "_lane3"}, 64'(c_l3[hi[k]]), 64'(e_l3[k]));
                check({tag, "_vld3"},  64'(c_v3[hi[k]]), 64'(e_v3[k]));
            end
            check({tag, "_done_pos"}, 64'(c_done[hi[4]]), 64'(1));
            check({tag, "_gap"}, 64'(hi[4] - hi[0] + 1 - 5), 64'(exp_gap));
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] pack(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic send(input logic [W-1:0] d, input bit last);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!acc && guard < 64) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #2;
            guard++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got no in_ready expected accept within 64 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    // in_last and in_data are scrambled while idle; they must be ignored.
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            bus.in_last = 1'($urandom);
            bus.in_data = rnd();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_cap();
        cap_n  = 0;
        cap_en = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_n, first_hi, last_hi, d_idx, dn;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        bus.in_data  = rnd();
        rst_n        = 1'b0;

        // Reset held 5 cycles with in_valid high.
        repeat (5) begin
            @(negedge clk);
            check("rst_ready", 64'(bus.in_ready), 64'(0));
            check("rst_arr_en", 64'(bus.arr_en), 64'(0));
            check("rst_arr_data", 64'(bus.arr_data), 64'(0));
            check("rst_busy", 64'(bus.busy), 64'(0));
            check("rst_done", 64'(bus.done), 64'(0));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // Single tile, no bubble.
        start_cap();
        send(pack(1, 2, 3, 4), 1'b0);
        send(pack(5, 6, 7, 8), 1'b1);
        idle(8);
        cap_en = 0;
        analyze_tile("tile", 0);

        // Same tile with a 2-cycle bubble.
        start_cap();
        send(pack(1, 2, 3, 4), 1'b0);
        idle(2);
        send(pack(5, 6, 7, 8), 1'b1);
        idle(8);
        cap_en = 0;
        analyze_tile("bubble", 2);

        // Back-to-back tiles.
        start_cap();
        send(pack(1, 2, 3, 4), 1'b0);
        send(pack(5, 6, 7, 8), 1'b1);
        send(pack(9, 10, 11, 12), 1'b0);
        send(pack(13, 14, 15, 16), 1'b1);
        idle(8);
        cap_en = 0;
        hi_n = 0; first_hi = -1; last_hi = -1; d_idx = -1; dn = 0;
        for (int i = 0; i < cap_n; i++) begin
            if (c_en[i]) begin
                hi_n++;
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
            if (c_done[i]) begin
                dn++;
                if (d_idx < 0) d_idx = i;
            end
        end
        check("b2b_en_count", 64'(hi_n), 64'(10));
        check("b2b_contiguous", 64'(last_hi - first_hi + 1), 64'(10));
        check("b2b_done_count", 64'(dn), 64'(2));
        if (d_idx >= 0 && d_idx + 1 < cap_n) begin
            check("b2b_next_en", 64'(c_en[d_idx + 1]), 64'(1));
            check("b2b_next_lane0", 64'(c_l0[d_idx + 1]), 64'(9));
        end else begin
            check("b2b_done_found", 64'(d_idx), 64'(cap_n));
        end

        // Reset during the 2nd flush step.
        send(pack(1, 2, 3, 4), 1'b0);
        send(pack(5, 6, 7, 8), 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_arr_en", 64'(bus.arr_en), 64'(0));
        check("mrst_busy", 64'(bus.busy), 64'(0));
        check("mrst_ready", 64'(bus.in_ready), 64'(1));
        check("mrst_done", 64'(bus.done), 64'(0));
        repeat (4) begin
            @(negedge clk);
            check("mrst_no_done", 64'(bus.done), 64'(0));
        end
        @(posedge clk);
        #2;

        // Randomized traffic against the model.
        for (int v = 0; v < 400; v++) begin
            send(rnd(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        send(rnd(), 1'b1);
        idle(10);

`ifdef SKEW_FEEDER_STATS_EN
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            send(rnd(), 1'b0);
            send(rnd(), 1'b1);
        end
        idle(8);
        @(negedge clk);
        check("stat_beats_final", 64'(bus.stat_beats), 64'(6));
        check("stat_tiles_final", 64'(bus.stat_tiles), 64'(3));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
